// File: rtl/phase_detector.sv
// Synchronous phase detector: measures ref-to-fb edge separation in clk cycles and
// emits a signed error strobe. Define PD_LOCK_DET_EN to compile in the lock detector.
module phase_detector #(
    parameter int ERR_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 4,
    parameter int LOCK_CNT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic                    phase_valid,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    timeout,
    output logic                    locked
);
    localparam int CNT_W = ERR_W - 1;
    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, LEAD_REF, LEAD_FB} state_t;

    if (SYNC_STAGES < 2 || LOCK_CNT < 1 || LOCK_TOL < 0) begin : g_param_check
        $error("phase_detector: invalid parameter set");
    end

    logic [SYNC_STAGES-1:0]  ref_sync_q, fb_sync_q;
    logic                    ref_prev_q, fb_prev_q;
    logic                    ref_rise_q, fb_rise_q;
    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    phase_valid_q, timeout_q;
    logic signed [ERR_W-1:0] phase_err_q;
    logic signed [ERR_W-1:0] cnt_pos, cnt_neg, max_pos, max_neg;

    // Synchronizers and edge detectors ignore ena so re-enabling cannot fake an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_sync_q <= '0;
            fb_sync_q  <= '0;
            ref_prev_q <= 1'b0;
            fb_prev_q  <= 1'b0;
            ref_rise_q <= 1'b0;
            fb_rise_q  <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
            fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], fb_in};
            ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
            fb_prev_q  <= fb_sync_q[SYNC_STAGES-1];
            ref_rise_q <= ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
            fb_rise_q  <= fb_sync_q[SYNC_STAGES-1] & ~fb_prev_q;
        end
    end

    always_comb begin
        cnt_pos = $signed({1'b0, cnt_q});
        cnt_neg = -cnt_pos;
        max_pos = $signed({1'b0, MAX});
        max_neg = -max_pos;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            phase_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            phase_err_q   <= '0;
        end else begin
            phase_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            if (!ena) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ref_rise_q && fb_rise_q) begin
                            phase_valid_q <= 1'b1;
                            phase_err_q   <= '0;
                        end else if (ref_rise_q) begin
                            state_q <= LEAD_REF;
                            cnt_q   <= CNT_W'(1);
                        end else if (fb_rise_q) begin
                            state_q <= LEAD_FB;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    LEAD_REF: begin
                        if (fb_rise_q) begin
                            phase_valid_q <= 1'b1;
                            phase_err_q   <= cnt_pos;
                            state_q       <= ref_rise_q ? LEAD_REF : IDLE;
                            cnt_q         <= ref_rise_q ? CNT_W'(1) : '0;
                        end else if (ref_rise_q) begin
                            phase_valid_q <= 1'b1;
                            phase_err_q   <= max_pos;
                            cnt_q         <= CNT_W'(1);
                        end else if (cnt_q == MAX) begin
                            phase_valid_q <= 1'b1;
                            timeout_q     <= 1'b1;
                            phase_err_q   <= max_pos;
                            state_q       <= IDLE;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    LEAD_FB: begin
                        if (ref_rise_q) begin
                            phase_valid_q <= 1'b1;
                            phase_err_q   <= cnt_neg;
                            state_q       <= fb_rise_q ? LEAD_FB : IDLE;
                            cnt_q         <= fb_rise_q ? CNT_W'(1) : '0;
                        end else if (fb_rise_q) begin
                            phase_valid_q <= 1'b1;
                            phase_err_q   <= max_neg;
                            cnt_q         <= CNT_W'(1);
                        end else if (cnt_q == MAX) begin
                            phase_valid_q <= 1'b1;
                            timeout_q     <= 1'b1;
                            phase_err_q   <= max_neg;
                            state_q       <= IDLE;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        phase_valid = phase_valid_q;
        phase_err   = phase_err_q;
        timeout     = timeout_q;
    end

`ifdef PD_LOCK_DET_EN
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    logic [GOOD_W-1:0]       good_q;
    logic                    locked_q;
    logic                    in_tol;
    logic signed [ERR_W-1:0] tol_s;

    always_comb begin
        tol_s  = ERR_W'(LOCK_TOL);
        in_tol = (phase_err_q <= tol_s) && (phase_err_q >= -tol_s);
    end

    // Watches the registered strobe, so locked trails the qualifying strobe by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_q   <= '0;
            locked_q <= 1'b0;
        end else if (!ena || timeout_q) begin
            good_q   <= '0;
            locked_q <= 1'b0;
        end else if (phase_valid_q) begin
            if (in_tol) begin
                if (good_q != GOOD_W'(LOCK_CNT))
                    good_q <= good_q + 1'b1;
                locked_q <= (good_q >= GOOD_W'(LOCK_CNT - 1));
            end else begin
                good_q   <= '0;
                locked_q <= 1'b0;
            end
        end
    end

    always_comb locked = locked_q;
`else
    always_comb locked = 1'b0;
`endif

endmodule

// File: tb/tb_phase_detector.sv
// Directed bench for phase_detector: expected strobes are queued as stimulus is
// driven and popped by a negedge monitor when the DUT strobes.
module tb_phase_detector;
    localparam int ERR_W = 16;
    localparam int MAX   = 32767;

    logic clk = 1'b0;
    logic rst, ena, ref_in, fb_in;
    logic phase_valid, timeout, locked;
    logic signed [ERR_W-1:0] phase_err;

    logic s_ena, s_ref, s_fb;
    logic s_valid, s_timeout, s_locked;
    logic signed [7:0] s_err;

    int errors  = 0;
    int checks  = 0;
    int strobes = 0;
    bit mon_en  = 1'b0;

    int exp_err_q[$];
    bit exp_to_q[$];

    always #5 clk = ~clk;

    phase_detector #(.ERR_W(ERR_W), .SYNC_STAGES(2), .LOCK_TOL(4), .LOCK_CNT(16)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .ref_in(ref_in), .fb_in(fb_in),
        .phase_valid(phase_valid), .phase_err(phase_err), .timeout(timeout), .locked(locked)
    );

    phase_detector #(.ERR_W(8)) u_small (
        .clk(clk), .rst(rst), .ena(s_ena), .ref_in(s_ref), .fb_in(s_fb),
        .phase_valid(s_valid), .phase_err(s_err), .timeout(s_timeout), .locked(s_locked)
    );

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (phase_valid === 1'b1) begin
                strobes++;
                checks++;
                assert (exp_err_q.size() != 0) else begin
                    errors++;
                    $error("FAIL strobe_unexpected observed err=%0d timeout=%0b expected no strobe",
                           phase_err, timeout);
                end
                if (exp_err_q.size() != 0) begin
                    int e;
                    bit t;
                    e = exp_err_q.pop_front();
                    t = exp_to_q.pop_front();
                    checks++;
                    assert (int'(phase_err) === e && timeout === t) else begin
                        errors++;
                        $error("FAIL strobe_value observed err=%0d timeout=%0b expected err=%0d timeout=%0b",
                               phase_err, timeout, e, t);
                    end
                end
            end else if (timeout !== 1'b0) begin
                checks++;
                errors++;
                $error("FAIL timeout_without_valid observed timeout=%0b valid=%0b expected 0", timeout, phase_valid);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_strobe(input int e, input bit t);
        exp_err_q.push_back(e);
        exp_to_q.push_back(t);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_err_q.size() != 0 && n < 64) begin
            tick(1);
            n++;
        end
        chk(tag, exp_err_q.size(), 0);
        exp_err_q.delete();
        exp_to_q.delete();
    endtask

    // n>0: ref leads fb by n cycles; n<0: fb leads by -n; n==0: coincident
    task automatic pair(input int n);
        expect_strobe(n, 1'b0);
        if (n > 0) begin
            ref_in = 1'b1; tick(n); fb_in = 1'b1;
        end else if (n < 0) begin
            fb_in = 1'b1; tick(-n); ref_in = 1'b1;
        end else begin
            ref_in = 1'b1; fb_in = 1'b1;
        end
        tick(3);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        tick(6);
        drain($sformatf("pair_%0d_pending", n));
        chk("err_hold", phase_err, n);
    endtask

    initial begin
        int n;
        int saved;
        rst = 1'b1; ena = 1'b0; ref_in = 1'b0; fb_in = 1'b0;
        s_ena = 1'b1; s_ref = 1'b0; s_fb = 1'b0;
        tick(3);
        chk("reset_valid", phase_valid, 0);
        chk("reset_err", phase_err, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_locked", locked, 0);

        rst = 1'b0; ena = 1'b1; mon_en = 1'b1;
        tick(1000);
        chk("idle_strobes", strobes, 0);
        chk("idle_err", phase_err, 0);

        pair(7);
        pair(-7);
        pair(1);
        pair(-1);
        pair(0);

        // Cycle slip: second ref edge before fb emits +MAX, then measurement restarts
        expect_strobe(MAX, 1'b0);
        expect_strobe(5, 1'b0);
        ref_in = 1'b1; tick(3); ref_in = 1'b0; tick(3);
        ref_in = 1'b1; tick(5); fb_in = 1'b1; tick(3);
        ref_in = 1'b0; fb_in = 1'b0; tick(6);
        drain("slip_pending");
        chk("slip_err_hold", phase_err, 5);

        // Drop ena mid-measurement, then re-enable while fb is held high
        saved = strobes;
        ref_in = 1'b1; tick(6);
        ena = 1'b0; tick(2);
        ref_in = 1'b0; fb_in = 1'b1; tick(6);
        ena = 1'b1; tick(10);
        fb_in = 1'b0; tick(5);
        chk("ena_drop_strobes", strobes - saved, 0);
        chk("ena_drop_err_hold", phase_err, 5);
        pair(4);

        // Small instance timeout: MAX=127
        s_ref = 1'b1;
        n = 0;
        while (s_valid !== 1'b1 && n < 200) begin tick(1); n++; end
        chk("small_timeout_latency", n, 131);
        chk("small_timeout_err", s_err, 127);
        chk("small_timeout_flag", s_timeout, 1);
        tick(1);
        chk("small_valid_pulse", s_valid, 0);
        chk("small_timeout_pulse", s_timeout, 0);
        chk("small_locked", s_locked, 0);
        s_ref = 1'b0; tick(4);
        s_ref = 1'b1; tick(3); s_fb = 1'b1;
        n = 0;
        while (s_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        chk("small_after_timeout_err", s_err, 3);
        chk("small_after_timeout_flag", s_timeout, 0);
        s_ref = 1'b0; s_fb = 1'b0;

        // Reset while in LEAD_REF
        ref_in = 1'b1; tick(6);
        rst = 1'b1; #1;
        chk("rst_mid_valid", phase_valid, 0);
        chk("rst_mid_err", phase_err, 0);
        chk("rst_mid_timeout", timeout, 0);
        chk("rst_mid_locked", locked, 0);
        ref_in = 1'b0; tick(2);
        rst = 1'b0; tick(3);
        pair(9);

        // Lock detector: 16 in-tolerance measurements, then one outside
        for (int i = 0; i < 16; i++) begin
            pair((i % 2 == 0) ? 3 : -3);
`ifdef PD_LOCK_DET_EN
            if (i == 14) chk("lock_before_16th", locked, 0);
            if (i == 15) chk("lock_after_16th", locked, 1);
`else
            if (i == 15) chk("lock_tied_low", locked, 0);
`endif
        end
        pair(5);
        chk("lock_after_out_of_tol", locked, 0);

        tick(5);
        chk("final_queue_empty", exp_err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_detector.md
# phase_detector

Synchronous phase detector directly upstream of the PI loop filter. It samples the asynchronous reference and feedback (DCO-divided) edges, measures their separation in `clk` cycles, and emits a signed `phase_err` with a one-cycle `phase_valid` strobe. This matches the filter's `phase_valid`/`phase_err` input contract.

## Interface

- `ERR_W`, 16: `phase_err` width (signed); `MAX = 2^(ERR_W-1)-1`.
- `SYNC_STAGES`, 2: synchronizer depth on `ref_in`/`fb_in` (≥2).
- `LOCK_TOL`, 4: in-lock magnitude tolerance on `phase_err` (cycles).
- `LOCK_CNT`, 16: consecutive in-tolerance measurements required for lock.

- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ena`  in  1  measurement enable.
- `ref_in`  in  1  reference edge input, asynchronous.
- `fb_in`  in  1  feedback edge input, asynchronous.
- `phase_valid`  out  1  one-cycle strobe; a new `phase_err` is valid.
- `phase_err`  out  ERR_W  signed error. Positive when ref leads fb. Holds its value between strobes.
- `timeout`  out  1  one-cycle strobe when a measurement saturates at MAX.
- `locked`  out  1  lock indicator. Constant 0 unless the lock detector is compiled in.

## Operation

- Each input passes `SYNC_STAGES` flops, then a registered rising-edge detector produces `ref_rise`/`fb_rise` pulses. Synchronizers run regardless of `ena`, so re-enabling never creates a false edge.
- The FSM has states IDLE, LEAD_REF and LEAD_FB. It uses an unsigned counter `cnt` of width ERR_W-1 that saturates at MAX.
- **IDLE**
  - Both edges in the same cycle: emit err=0, stay in IDLE.
  - `ref_rise` only: go to LEAD_REF, `cnt<=1`.
  - `fb_rise` only: go to LEAD_FB, `cnt<=1`.
- **LEAD_REF**
  - `fb_rise` arrives: emit `+cnt`.
    - If `ref_rise` arrives in the same cycle, go to LEAD_REF with `cnt<=1`.
    - Otherwise go to IDLE.
  - `ref_rise` without `fb_rise` (cycle slip): emit `+MAX`, stay in LEAD_REF, `cnt<=1`.
  - `cnt==MAX` with no edge: emit `+MAX`, pulse `timeout`, go to IDLE.
  - Otherwise `cnt<=cnt+1`.
- **LEAD_FB** mirrors LEAD_REF with the roles of ref and fb swapped and every emitted value negated (`-cnt`, `-MAX`).
- "Emit" means `phase_err` and `phase_valid=1` are registered on the next edge. `-MAX` is always representable, so no clipping is needed.
- `ena=0` forces IDLE, clears `cnt`, and suppresses `phase_valid`/`timeout`. `phase_err` holds its last value. The lock detector is cleared.
- Reset mid-measurement discards the measurement and emits nothing.

## Timing

- Reset values: `phase_valid=0`, `phase_err=0`, `timeout=0`, `locked=0`, FSM=IDLE, `cnt=0`, synchronizer and edge flops 0.
- Pin-to-pulse latency: `SYNC_STAGES+1` cycles.
- `fb_rise` N cycles after `ref_rise` (1≤N≤MAX) → `phase_err=+N`, `phase_valid` high in the cycle after `fb_rise`.
- Coincident edges → `phase_err=0` one cycle later.
- Timeout: `timeout` and `phase_valid` are high together, MAX+1 cycles after the leading edge.
- Maximum strobe rate is one per cycle. Strobes are never merged or dropped.

## Configuration

- Macro `PD_LOCK_DET_EN` compiles in the lock detector.
- Defined:
  - On each `phase_valid` with `|phase_err|≤LOCK_TOL`, a good-counter increments, saturating at LOCK_CNT.
  - Any other `phase_valid` clears the counter and deasserts `locked` on the next cycle.
  - `locked` rises the cycle after the LOCK_CNT-th consecutive good strobe.
  - Timeout, `ena=0` and `rst` clear both the counter and `locked`.
- Undefined: `locked` is tied to 0 and no counter logic is present.

## Test plan

- Reset, then `ena=1` with no edges → all outputs 0, no strobes for 1000 cycles.
- ref rises, fb rises 7 cycles later, edges stable → `phase_err=+7` with a single `phase_valid`. Repeat with fb leading by 7 → `-7`.
- Both edges on the same `clk` edge → `phase_err=0`, one strobe. Ref twice without fb (slip) → `+MAX` (32767), then measurement restarts.
- ref only, `ERR_W=8` → after 128 cycles `timeout=1` and `phase_valid=1` with `phase_err=+127`, FSM back in IDLE. Drop `ena` mid-measurement → no strobe.
- `PD_LOCK_DET_EN`, `LOCK_CNT=16`: 16 measurements of ±3 → `locked=1` after the 16th. One measurement of +5 → `locked=0` the next cycle.
- Assert `rst` while in LEAD_REF → outputs 0 immediately. After release, the next valid pair measures correctly.
